// File: rtl/subleq_pkg.sv
// Shared definitions for the subleq32 memory responder: address map offsets,
// TX status layout and the decoded-region type.
package subleq_pkg;

   localparam int unsigned ADDR_W_DEF = 13;
   localparam int unsigned DATA_W     = 32;

   // I/O words sit at negative offsets from the top of the decoded space
   localparam int IO_TX_DATA = -4;
   localparam int IO_TX_STAT = -3;
   localparam int IO_RX_DATA = -2;
   localparam int IO_RX_STAT = -1;

   localparam int unsigned TXS_OVF_BIT   = 31;
   localparam int unsigned TXS_FULL_BIT  = 16;
   localparam int unsigned TXS_EMPTY_BIT = 15;
   localparam int unsigned TXS_CNT_W     = 15;

   typedef enum logic [2:0] {
      REG_RAM,
      REG_TX_DATA,
      REG_TX_STAT,
      REG_RX_DATA,
      REG_RX_STAT
   } region_e;

   function automatic logic [DATA_W-1:0] tx_stat_word(input logic ovf,
                                                      input logic full,
                                                      input logic empty,
                                                      input logic [TXS_CNT_W-1:0] cnt);
      logic [DATA_W-1:0] w;
      w = DATA_W'(cnt);
      w[TXS_OVF_BIT]   = ovf;
      w[TXS_FULL_BIT]  = full;
      w[TXS_EMPTY_BIT] = empty;
      return w;
   endfunction

endpackage

// File: rtl/subleq_fifo.sv
// Power-of-two FIFO with a registered head word and a separate occupancy count.
module subleq_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [WIDTH-1:0]         head
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] cnt;
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt == CNT_W'(DEPTH));
   assign empty   = (cnt == '0);
   assign count   = cnt;
   assign do_pop  = pop && !empty && !rst;
   // a pop frees a slot in the same cycle, so a full FIFO still accepts
   assign do_push = push && (!full || do_pop) && !rst;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
         head   <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
         // head follows the next word; a lone entry replaced by din skips the array
         if (do_pop) begin
            head <= (cnt == CNT_W'(1)) ? din : mem[rd_ptr + PTR_W'(1)];
         end else if (do_push && empty) begin
            head <= din;
         end
      end
   end

endmodule

// File: rtl/subleq_mem32_resp.sv
// Memory-side responder for the subleq32 core: word RAM with one-cycle read
// latency, plus a TX FIFO and an RX mailbox mapped onto the top four words.
module subleq_mem32_resp
   import subleq_pkg::*;
#(
   parameter int unsigned ADDR_W     = ADDR_W_DEF,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic        iClock,
   input  logic        iReset,
   input  logic [31:0] iAddress,
   input  logic [31:0] iData,
   input  logic        iWren,
   output logic [31:0] oQ,
   output logic [31:0] oTxData,
   output logic        oTxValid,
   input  logic        iTxReady,
   input  logic [31:0] iRxData,
   input  logic        iRxValid,
   output logic        oRxReady
);

   localparam int unsigned RAM_WORDS = (2 ** ADDR_W) - 4;
   localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;

   localparam logic [ADDR_W-1:0] A_TX_DATA = ADDR_W'(IO_TX_DATA);
   localparam logic [ADDR_W-1:0] A_TX_STAT = ADDR_W'(IO_TX_STAT);
   localparam logic [ADDR_W-1:0] A_RX_DATA = ADDR_W'(IO_RX_DATA);
   localparam logic [ADDR_W-1:0] A_RX_STAT = ADDR_W'(IO_RX_STAT);

   logic [DATA_W-1:0] ram [RAM_WORDS];
   logic [ADDR_W-1:0] addr;
   region_e           region;
   logic              wr_en;
   logic              push;
   logic              pop;
   logic              ack;
   logic              accept;
   logic              tx_full;
   logic              tx_empty;
   logic [CNT_W-1:0]  tx_count;
   logic              ovf;
   logic              rx_valid;
   logic [DATA_W-1:0] rx_data;
   logic [DATA_W-1:0] rd_word;
   logic              unused_addr;

   // upper address bits alias onto the decoded window
   assign addr        = iAddress[ADDR_W-1:0];
   assign unused_addr = ^iAddress[31:ADDR_W];

   always_comb begin
      region = REG_RAM;
      if (addr == A_TX_DATA)      region = REG_TX_DATA;
      else if (addr == A_TX_STAT) region = REG_TX_STAT;
      else if (addr == A_RX_DATA) region = REG_RX_DATA;
      else if (addr == A_RX_STAT) region = REG_RX_STAT;
   end

   assign wr_en  = iWren && !iReset;
   assign push   = wr_en && (region == REG_TX_DATA);
   assign pop    = oTxValid && iTxReady;
   assign ack    = wr_en && (region == REG_RX_DATA);
   assign accept = iRxValid && !rx_valid;

   subleq_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .clk   (iClock),
      .rst   (iReset),
      .push  (push),
      .pop   (pop),
      .din   (iData),
      .full  (tx_full),
      .empty (tx_empty),
      .count (tx_count),
      .head  (oTxData)
   );

   assign oTxValid = !tx_empty;
   assign oRxReady = !rx_valid;

   // RAM is deliberately outside reset so its contents survive it
   always_ff @(posedge iClock) begin
      if (wr_en && (region == REG_RAM)) begin
         ram[addr] <= iData;
      end
   end

   always_ff @(posedge iClock) begin
      if (iReset) begin
         ovf <= 1'b0;
      end else if (wr_en && (region == REG_TX_STAT)) begin
         ovf <= 1'b0;
      end else if (push && tx_full && !pop) begin
         ovf <= 1'b1;
      end
   end

   // a host word is only taken while the mailbox is empty, so an ack never races it
   always_ff @(posedge iClock) begin
      if (iReset) begin
         rx_valid <= 1'b0;
         rx_data  <= '0;
      end else if (accept) begin
         rx_valid <= 1'b1;
         rx_data  <= iRxData;
      end else if (ack) begin
         rx_valid <= 1'b0;
      end
   end

   always_comb begin
      rd_word = '0;
      unique case (region)
         REG_RAM:     rd_word = ram[addr];
         REG_TX_DATA: rd_word = '0;
         REG_TX_STAT: rd_word = tx_stat_word(ovf, tx_full, tx_empty, TXS_CNT_W'(tx_count));
         REG_RX_DATA: rd_word = rx_data;
         REG_RX_STAT: rd_word = DATA_W'(rx_valid);
         default:     rd_word = '0;
      endcase
   end

   // sampling pre-edge state gives old-data on read-during-write
   always_ff @(posedge iClock) begin
      if (iReset) begin
         oQ <= '0;
      end else begin
         oQ <= rd_word;
      end
   end

endmodule
